// File: rtl/imem_boot_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_boot_ctrl_pkg
//  Description : Shared constants and state encoding for the UART boot loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_boot_ctrl_pkg;

    localparam int          c_ROM_SIZE_BIT = 6;
    localparam logic [7:0]  c_MAGIC        = 8'hA5;
    localparam logic [31:0] c_NOP          = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_RUN  = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/imem_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : imem_word_packer
//  Description : Packs an MSB-first byte stream into 32-bit words.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_ready
);

    logic [1:0]  r_byte_cnt;
    logic [23:0] r_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_cnt <= 2'd0;
            r_shift    <= 24'd0;
        end else if (i_clr) begin
            r_byte_cnt <= 2'd0;
        end else if (i_byte_valid) begin
            r_shift    <= {r_shift[15:0], i_byte};
            r_byte_cnt <= r_byte_cnt + 2'd1;
        end
    end

    // The fourth byte is folded in combinationally so the word is ready on its own strobe.
    assign o_word       = {r_shift, i_byte};
    assign o_word_ready = i_byte_valid && (r_byte_cnt == 2'd3);

endmodule
`default_nettype wire

// File: rtl/imem_boot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : imem_boot_ctrl
//  Description : Loads instruction RAM from a checksummed UART frame, holds CPU until valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_ctrl
    import imem_boot_ctrl_pkg::*;
#(
    parameter int         ROM_SIZE_BIT = c_ROM_SIZE_BIT,
    parameter int         ROM_SIZE     = 2 ** ROM_SIZE_BIT,
    parameter logic [7:0] MAGIC        = c_MAGIC,
    parameter int         ALLOW_RELOAD = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    input  logic [31:0]             fetch_addr,
    output logic [31:0]             fetch_data,
    output logic [ROM_SIZE_BIT-1:0] mem_raddr,
    input  logic [31:0]             mem_rdata,
    output logic                    mem_we,
    output logic [ROM_SIZE_BIT-1:0] mem_waddr,
    output logic [31:0]             mem_wdata,
    output logic                    cpu_hold,
    output logic                    boot_done,
    output logic                    boot_err
);

    localparam int         c_CW       = ROM_SIZE_BIT + 1;
    localparam logic [8:0] c_ROM_SIZE = 9'(ROM_SIZE);

    state_t                  r_state;
    logic [c_CW-1:0]         r_len;
    logic [c_CW-1:0]         r_word_cnt;
    logic [7:0]              r_csum;
    logic                    r_mem_we;
    logic [ROM_SIZE_BIT-1:0] r_mem_waddr;
    logic [31:0]             r_mem_wdata;
    logic                    r_cpu_hold;
    logic                    r_boot_done;
    logic                    r_boot_err;

    logic                    w_len_bad;
    logic                    w_len_accept;
    logic                    w_data_byte;
    logic [31:0]             w_word;
    logic                    w_word_ready;
    logic                    w_unused_fetch;

    assign w_len_bad    = (rx_data == 8'd0) || ({1'b0, rx_data} > c_ROM_SIZE);
    assign w_len_accept = rx_valid && (r_state == ST_LEN) && !w_len_bad;
    assign w_data_byte  = rx_valid && (r_state == ST_DATA);

    imem_word_packer u_packer (
        .clk          (clk),
        .rst          (reset),
        .i_clr        (w_len_accept),
        .i_byte_valid (w_data_byte),
        .i_byte       (rx_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_csum      <= 8'd0;
            r_mem_we    <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= 32'd0;
            r_cpu_hold  <= 1'b1;
            r_boot_done <= 1'b0;
            r_boot_err  <= 1'b0;
        end else begin
            r_mem_we <= 1'b0;
            if (rx_valid) begin
                case (r_state)
                    ST_IDLE: begin
                        if (rx_data == MAGIC) begin
                            r_state    <= ST_LEN;
                            r_boot_err <= 1'b0;
                        end
                    end
                    ST_LEN: begin
                        if (w_len_bad) begin
                            r_state    <= ST_ERR;
                            r_boot_err <= 1'b1;
                            r_cpu_hold <= 1'b1;
                        end else begin
                            r_len      <= rx_data[c_CW-1:0];
                            r_csum     <= rx_data;
                            r_word_cnt <= '0;
                            r_state    <= ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        r_csum <= r_csum ^ rx_data;
                        if (w_word_ready) begin
                            r_mem_we    <= 1'b1;
                            r_mem_waddr <= r_word_cnt[ROM_SIZE_BIT-1:0];
                            r_mem_wdata <= w_word;
                            r_word_cnt  <= r_word_cnt + c_CW'(1);
                            if (r_word_cnt == (r_len - c_CW'(1)))
                                r_state <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        if (rx_data == r_csum) begin
                            r_state     <= ST_RUN;
                            r_cpu_hold  <= 1'b0;
                            r_boot_done <= 1'b1;
                        end else begin
                            r_state    <= ST_ERR;
                            r_boot_err <= 1'b1;
                            r_cpu_hold <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        // Without reload the running program owns the UART.
                        if ((ALLOW_RELOAD != 0) && (rx_data == MAGIC)) begin
                            r_state     <= ST_LEN;
                            r_cpu_hold  <= 1'b1;
                            r_boot_done <= 1'b0;
                        end
                    end
                    ST_ERR: begin
                        if (rx_data == MAGIC) begin
                            r_state    <= ST_LEN;
                            r_boot_err <= 1'b0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign mem_raddr      = fetch_addr[ROM_SIZE_BIT+1:2];
    assign fetch_data     = r_cpu_hold ? c_NOP : mem_rdata;
    assign w_unused_fetch = ^{fetch_addr[31:ROM_SIZE_BIT+2], fetch_addr[1:0]};

    assign mem_we    = r_mem_we;
    assign mem_waddr = r_mem_waddr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_hold  = r_cpu_hold;
    assign boot_done = r_boot_done;
    assign boot_err  = r_boot_err;

endmodule
`default_nettype wire
